// File: rtl/fan_duty_if.sv
// Avalon-MM register bus plus the period/duty handoff to the PWM output stage.
interface fan_duty_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        cfg_valid;
    logic        cfg_ack;
    logic [31:0] period_ticks;
    logic [31:0] duty_ticks;
    logic [9:0]  duty_permille;

    modport master (output address, write, writedata, read, cfg_ack,
                    input  readdata, waitrequest, cfg_valid, period_ticks, duty_ticks, duty_permille);
    modport slave  (input  address, write, writedata, read, cfg_ack,
                    output readdata, waitrequest, cfg_valid, period_ticks, duty_ticks, duty_permille);
endinterface

// File: rtl/fan_duty_scheduler.sv
// Fixed-rate fan duty control loop: target curve, ramp limit, tick conversion, PWM handoff.
// Define FAN_STALL_DETECT_EN to add tach-based stall detection (tach input, fan_fault output).
module fan_duty_scheduler #(
    parameter int CLOCK_SPEED_HZ = 50_000_000,
    parameter int UPDATE_HZ      = 100
`ifdef FAN_STALL_DETECT_EN
    , parameter int STALL_WINDOWS = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    fan_duty_if.slave          bus,
    input  logic signed [31:0] current_average
`ifdef FAN_STALL_DETECT_EN
    , input  logic             tach
    , output logic             fan_fault
`endif
);
    localparam int          TICK_DIV   = CLOCK_SPEED_HZ / UPDATE_HZ;
    localparam logic [31:0] CLK_HZ     = 32'(CLOCK_SPEED_HZ);
    localparam logic [31:0] PERIOD_RST = 32'(CLOCK_SPEED_HZ / 1000);

    typedef enum logic [2:0] {
        IDLE = 3'd0, CALC_PERIOD = 3'd1, INTERP = 3'd2, RAMP = 3'd3, CALC_TICKS = 3'd4, HANDOFF = 3'd5
    } state_t;
    state_t state, state_nx;

    logic               mode_r, s_mode;
    logic [9:0]         manual_r, min_r, ramp_r, s_manual, s_min, s_ramp;
    logic signed [31:0] low_r, high_r, s_low, s_high, s_avg;
    logic [31:0]        freq_r, s_freq, tick_cnt, period_calc, reg_rd;
    logic [9:0]         target, target_nx, cur, cur_nx;
    logic               tick, rd_pend, stall_bit;
    logic [31:0]        readdata_q, period_q, duty_q;
    logic [9:0]         duty_pm_q;
    logic               cfg_valid_q;

    // divider: cycle 0 loads operands, cycles 1..32 shift/subtract
    logic [5:0]  div_cnt;
    logic [31:0] div_rem, div_quo, div_dvs, rem_nx, quo_nx, divisor, diff_u, span_u;
    logic [63:0] dividend;
    logic [32:0] div_shift;
    logic        div_active, div_done;

    function automatic logic [9:0] clamp_pm(input logic [31:0] d);
        if ($signed(d) < 0)    return 10'd0;
        if ($signed(d) > 1000) return 10'd1000;
        return d[9:0];
    endfunction

    assign tick       = (tick_cnt == 32'(TICK_DIV - 1));
    assign div_active = (state == CALC_PERIOD) || (state == CALC_TICKS) || (state == INTERP && s_mode);
    assign div_done   = div_active && (div_cnt == 6'd32);
    assign diff_u     = s_avg - s_low;
    assign span_u     = s_high - s_low;

    always_comb begin
        dividend = {32'd0, CLK_HZ};
        divisor  = s_freq;
        if (state == INTERP) begin
            dividend = 64'(diff_u) * 64'(10'd1000 - s_min);
            divisor  = span_u;
        end else if (state == CALC_TICKS) begin
            dividend = 64'(cur) * 64'(period_calc);
            divisor  = 32'd1000;
        end
        div_shift = {div_rem, div_quo[31]};
        if (div_shift >= {1'b0, div_dvs}) begin
            rem_nx = 32'(div_shift - {1'b0, div_dvs});
            quo_nx = {div_quo[30:0], 1'b1};
        end else begin
            rem_nx = div_shift[31:0];
            quo_nx = {div_quo[30:0], 1'b0};
        end
    end

    // an inverted or empty threshold window degenerates to a step at thr_high
    always_comb begin
        target_nx = s_min;
        if (!s_mode)                target_nx = s_manual;
        else if (s_high <= s_low)   target_nx = (s_avg >= s_high) ? 10'd1000 : s_min;
        else if (s_avg <= s_low)    target_nx = s_min;
        else if (s_avg >= s_high)   target_nx = 10'd1000;
        else                        target_nx = s_min + quo_nx[9:0];
        cur_nx = target;
        if (s_ramp != 10'd0) begin
            if (target > cur && (target - cur) > s_ramp)      cur_nx = cur + s_ramp;
            else if (cur > target && (cur - target) > s_ramp) cur_nx = cur - s_ramp;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (tick) state_nx = CALC_PERIOD;
            CALC_PERIOD: if (div_done) state_nx = INTERP;
            INTERP:      if (!s_mode || div_done) state_nx = RAMP;
            RAMP:        state_nx = CALC_TICKS;
            CALC_TICKS:  if (div_done) state_nx = HANDOFF;
            HANDOFF:     if (bus.cfg_ack) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0; div_rem <= '0; div_quo <= '0; div_dvs <= '0;
        end else if (div_active) begin
            if (div_cnt == 6'd0) begin
                div_rem <= dividend[63:32];
                div_quo <= dividend[31:0];
                div_dvs <= divisor;
            end else begin
                div_rem <= rem_nx;
                div_quo <= quo_nx;
            end
            div_cnt <= (div_cnt == 6'd32) ? 6'd0 : div_cnt + 6'd1;
        end else begin
            div_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            s_mode <= 1'b0; s_manual <= '0; s_min <= '0; s_ramp <= '0;
            s_low <= '0; s_high <= 32'sd1000; s_avg <= '0; s_freq <= 32'd1000;
            period_calc <= PERIOD_RST; target <= '0; cur <= '0;
            period_q <= PERIOD_RST; duty_q <= '0; duty_pm_q <= '0; cfg_valid_q <= 1'b0;
        end else begin
            tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
            if (state == IDLE && tick) begin
                s_mode <= mode_r; s_manual <= manual_r; s_min <= min_r; s_ramp <= ramp_r;
                s_low <= low_r; s_high <= high_r; s_avg <= current_average; s_freq <= freq_r;
            end
            if (state == CALC_PERIOD && div_done) period_calc <= quo_nx;
            if (state == INTERP && state_nx == RAMP) target <= target_nx;
            if (state == RAMP) cur <= cur_nx;
            if (state == CALC_TICKS && div_done) begin
                period_q    <= period_calc;
                duty_q      <= quo_nx;
                cfg_valid_q <= 1'b1;
            end
            if (state == HANDOFF && bus.cfg_ack) begin
                cfg_valid_q <= 1'b0;
                duty_pm_q   <= cur;
            end
        end
    end

    always_comb begin
        reg_rd = {7'd0, stall_bit, 6'd0, duty_pm_q, 5'd0, state};
        case (bus.address)
            3'd0:    reg_rd = {31'd0, mode_r};
            3'd1:    reg_rd = {22'd0, manual_r};
            3'd2:    reg_rd = low_r;
            3'd3:    reg_rd = high_r;
            3'd4:    reg_rd = {22'd0, min_r};
            3'd5:    reg_rd = {22'd0, ramp_r};
            3'd6:    reg_rd = freq_r;
            default: ;
        endcase
    end

    // reads stall exactly one cycle so readdata comes from a register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r <= 1'b0; manual_r <= '0; low_r <= '0; high_r <= 32'sd1000;
            min_r <= '0; ramp_r <= '0; freq_r <= 32'd1000;
            rd_pend <= 1'b0; readdata_q <= '0;
        end else begin
            if (bus.write) begin
                case (bus.address)
                    3'd0: mode_r   <= bus.writedata[0];
                    3'd1: manual_r <= clamp_pm(bus.writedata);
                    3'd2: low_r    <= bus.writedata;
                    3'd3: high_r   <= bus.writedata;
                    3'd4: min_r    <= clamp_pm(bus.writedata);
                    3'd5: ramp_r   <= clamp_pm(bus.writedata);
                    3'd6: freq_r   <= (bus.writedata == 32'd0) ? 32'd1 : bus.writedata;
                    default: ;
                endcase
            end
            if (rd_pend) rd_pend <= 1'b0;
            else if (bus.read) begin
                rd_pend    <= 1'b1;
                readdata_q <= reg_rd;
            end
        end
    end

`ifdef FAN_STALL_DETECT_EN
    logic [2:0] tach_sync;
    logic       tach_rise, tach_seen, stall_r;
    logic [7:0] zero_cnt;
    logic [9:0] stall_thr;

    assign tach_rise = tach_sync[1] & ~tach_sync[2];
    assign stall_thr = (min_r == 10'd0) ? 10'd1 : min_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tach_sync <= '0; tach_seen <= 1'b0; zero_cnt <= '0; stall_r <= 1'b0;
        end else begin
            tach_sync <= {tach_sync[1:0], tach};
            if (tick) begin
                tach_seen <= 1'b0;
                if (tach_seen || tach_rise) begin
                    zero_cnt <= '0;
                    stall_r  <= 1'b0;
                end else if (duty_pm_q >= stall_thr) begin
                    if (zero_cnt >= 8'(STALL_WINDOWS - 1)) stall_r <= 1'b1;
                    else zero_cnt <= zero_cnt + 8'd1;
                end else begin
                    zero_cnt <= '0;
                end
            end else if (tach_rise) begin
                tach_seen <= 1'b1;
            end
            if (bus.write && bus.address == 3'd7 && bus.writedata[24]) stall_r <= 1'b0;
        end
    end

    assign stall_bit = stall_r;
    assign fan_fault = stall_r;
`else
    assign stall_bit = 1'b0;
`endif

    assign bus.readdata      = readdata_q;
    assign bus.waitrequest   = bus.read & ~rd_pend;
    assign bus.cfg_valid     = cfg_valid_q;
    assign bus.period_ticks  = period_q;
    assign bus.duty_ticks    = duty_q;
    assign bus.duty_permille = duty_pm_q;
endmodule
